vga_line_fetch: RTL and testbench

- Video timing and pixel-group prefetch stage that sits directly downstream of the memory map.
- Generates VGA raster timing from a pixel strobe and drives the group/line fetch request (vga_en, vga_x_group, vga_y_val) into the memory map.
- Captures the returned 32-pixel BGR group into a ping-pong buffer and serialises pixels to the DAC with aligned hsync/vsync.
- Reports vblank, which the memory map exposes to software.

---
 rtl/vga_line_fetch.sv | 172 +++++++++++++++++
 tb/tb_vga_line_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// VGA raster timing plus 32-pixel group prefetch: requests groups from the memory
// map into a ping-pong buffer and serialises them to the DAC with aligned syncs.
module vga_line_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_stb_pix,
  input  logic [31:0][11:0] vga_bgr_buf,
  input  logic              buf_valid,
  output logic              vga_en,
  output logic [4:0]        vga_x_group,
  output logic [8:0]        vga_y_val,
  output logic              vga_vblank,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic [11:0]       bgr,
  output logic [7:0]        underrun_cnt
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT + 1);
  localparam int VW = $clog2(VT + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [4:0]    G_LAST = 5'(H_ACTIVE / 32 - 1);
  localparam logic [8:0]    Y_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic {F_IDLE = 1'b0, F_REQ = 1'b1} fetch_state_e;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;
  logic [11:0]       bgr_q, bgr_d;
  logic [31:0][11:0] front_q, front_d, back_q, back_d;
  logic              back_full_q, back_full_d, stale_q, stale_d;
  logic [4:0]        fg_q, fg_d, xg_q, xg_d;
  logic [8:0]        fy_q, fy_d, yv_q, yv_d;
  logic              en_q, en_d;
  logic [7:0]        ucnt_q, ucnt_d;
  fetch_state_e      st_q, st_d;
  logic              swap, take;
  logic [4:0]        g_nxt;

  function automatic logic [13:0] next_ptr(input logic [4:0] g, input logic [8:0] y);
    if (g == G_LAST) return {5'd0, (y == Y_LAST) ? 9'd0 : y + 9'd1};
    return {g + 5'd1, y};
  endfunction

  always_comb begin
    h_d = h_q;  v_d = v_q;
    hsync_d = hsync_q;  vsync_d = vsync_q;  vblank_d = vblank_q;  bgr_d = bgr_q;
    front_d = front_q;  back_d = back_q;  back_full_d = back_full_q;  stale_d = stale_q;
    fg_d = fg_q;  fy_d = fy_q;  st_d = st_q;  en_d = en_q;  xg_d = xg_q;  yv_d = yv_q;
    ucnt_d = ucnt_q;
    swap = 1'b0;  take = 1'b0;  g_nxt = '0;

    if (clk_stb_pix) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      hsync_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
      vblank_d = (v_q >= V_ACT);
      bgr_d    = ((h_q < H_ACT) && (v_q < V_ACT)) ? front_q[h_q[4:0]] : '0;
      g_nxt    = 5'(h_d >> 5);
      swap     = (h_d[4:0] == 5'd0) && (h_d < H_ACT) && (v_d < V_ACT);
    end

    take = (st_q == F_REQ) && buf_valid && !stale_q;
    if ((st_q == F_REQ) && buf_valid) begin
      en_d    = 1'b0;
      st_d    = F_IDLE;
      stale_d = 1'b0;
      if (!stale_q) {fg_d, fy_d} = next_ptr(fg_q, fy_q);
    end

    // A request only exists while back is empty, so take never coincides with back_full.
    if (swap) begin
      if (back_full_q) begin
        front_d     = back_q;
        back_full_d = 1'b0;
      end else if (take) begin
        front_d = vga_bgr_buf;
      end else begin
        front_d      = '0;
        ucnt_d       = (ucnt_q == 8'hFF) ? ucnt_q : ucnt_q + 8'd1;
        {fg_d, fy_d} = next_ptr(g_nxt, 9'(v_d));
        if ((st_q == F_REQ) && !buf_valid) stale_d = 1'b1;
      end
    end else if (take) begin
      back_d      = vga_bgr_buf;
      back_full_d = 1'b1;
    end

    // Issue from the post-underrun pointer so a same-cycle skip never fetches a dead group.
    if ((st_q == F_IDLE) && !back_full_q) begin
      st_d = F_REQ;
      en_d = 1'b1;
      xg_d = fg_d;
      yv_d = fy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q         <= '0;
      v_q         <= V_ACT;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      vblank_q    <= 1'b1;
      bgr_q       <= '0;
      front_q     <= '0;
      back_q      <= '0;
      back_full_q <= 1'b0;
      stale_q     <= 1'b0;
      fg_q        <= '0;
      fy_q        <= '0;
      st_q        <= F_IDLE;
      en_q        <= 1'b0;
      xg_q        <= '0;
      yv_q        <= '0;
      ucnt_q      <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      vblank_q    <= vblank_d;
      bgr_q       <= bgr_d;
      front_q     <= front_d;
      back_q      <= back_d;
      back_full_q <= back_full_d;
      stale_q     <= stale_d;
      fg_q        <= fg_d;
      fy_q        <= fy_d;
      st_q        <= st_d;
      en_q        <= en_d;
      xg_q        <= xg_d;
      yv_q        <= yv_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign vga_en       = en_q;
  assign vga_x_group  = xg_q;
  assign vga_y_val    = yv_q;
  assign vga_vblank   = vblank_q;
  assign hsync_n      = hsync_q;
  assign vsync_n      = vsync_q;
  assign bgr          = bgr_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch on a reduced raster: a memory responder answers fetches,
// and a raster model queues expected sync/pixel values checked one strobe later.
`timescale 1ns/1ps
module tb_vga_line_fetch;

  localparam int HA = 128, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NG = HA / 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              stb = 1'b0;
  logic [31:0][11:0] vga_bgr_buf;
  logic              buf_valid;
  logic              vga_en, vga_vblank, hsync_n, vsync_n;
  logic [4:0]        vga_x_group;
  logic [8:0]        vga_y_val;
  logic [11:0]       bgr;
  logic [7:0]        underrun_cnt;

  int n_chk = 0, n_err = 0;
  int hm = 0, vm = 0, frm = 0;
  logic sb_on = 1'b0, resp_on = 1'b0, resp_busy = 1'b0;
  logic [14:0] q_exp[$];

  vga_line_fetch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .clk_stb_pix(stb), .vga_bgr_buf(vga_bgr_buf),
    .buf_valid(buf_valid), .vga_en(vga_en), .vga_x_group(vga_x_group),
    .vga_y_val(vga_y_val), .vga_vblank(vga_vblank), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .bgr(bgr), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  // Pixel strobe every other clock, changed just after the edge so it is stable at negedge.
  initial forever begin
    @(posedge clk);
    #1 stb = ~stb;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0][11:0] fill(input logic [4:0] g, input logic [8:0] y);
    logic [31:0][11:0] r;
    for (int i = 0; i < 32; i++) r[i] = {y[3:0], g[3:0], 4'(i)};
    return r;
  endfunction

  // Frame 2 withholds group 2 of line 10, so that group must show black.
  function automatic logic [14:0] exp_out(input int h, input int v, input int f);
    logic [11:0] px;
    logic hs, vs, vb;
    px = 12'h000;
    if (h < HA && v < VA && !(f == 2 && v == 10 && h / 32 == 2))
      px = {4'(v), 4'(h / 32), 4'(h % 32)};
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    vb = (v >= VA);
    return {hs, vs, vb, px};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      hm <= 0;
      vm <= VA;
      frm <= 0;
      q_exp.delete();
    end else if (stb) begin
      if (sb_on) q_exp.push_back(exp_out(hm, vm, frm));
      if (hm == HT - 1) begin
        hm <= 0;
        if (vm == VT - 1) begin
          vm <= 0;
          frm <= frm + 1;
        end else begin
          vm <= vm + 1;
        end
      end else begin
        hm <= hm + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      check_eq("hsync_n", 32'(hsync_n), 32'(q_exp[0][14]));
      check_eq("vsync_n", 32'(vsync_n), 32'(q_exp[0][13]));
      check_eq("vblank",  32'(vga_vblank), 32'(q_exp[0][12]));
      check_eq("bgr",     32'(bgr), 32'(q_exp[0][11:0]));
      void'(q_exp.pop_front());
    end
  end

  // Memory responder: every request must be the successor of the previous expected one.
  initial begin
    logic [4:0] rg, eg;
    logic [8:0] ry, ey;
    int n;
    buf_valid = 1'b0;
    vga_bgr_buf = '0;
    eg = 5'd0;
    ey = 9'd0;
    forever begin
      @(negedge clk);
      if (resp_on && rst && vga_en) begin
        resp_busy = 1'b1;
        rg = vga_x_group;
        ry = vga_y_val;
        check_eq("req_x", 32'(rg), 32'(eg));
        check_eq("req_y", 32'(ry), 32'(ey));
        if (eg == 5'(NG - 1)) begin
          eg = 5'd0;
          ey = (ey == 9'(VA - 1)) ? 9'd0 : ey + 9'd1;
        end else begin
          eg = eg + 5'd1;
        end
        if (frm == 2 && rg == 5'd2 && ry == 9'd10) begin
          repeat (80) @(negedge clk);
        end else if (frm == 2 && rg == 5'd1 && ry == 9'd3) begin
          n = 0;
          while (!(stb && hm == 31 && vm == 3) && n < 300) begin
            @(negedge clk);
            n++;
          end
          check_eq("swap_align", 32'(n < 300), 32'd1);
        end else begin
          repeat (4) @(negedge clk);
        end
        check_eq("hold_en", 32'(vga_en), 32'd1);
        check_eq("hold_x", 32'(vga_x_group), 32'(rg));
        check_eq("hold_y", 32'(vga_y_val), 32'(ry));
        vga_bgr_buf = fill(rg, ry);
        buf_valid = 1'b1;
        @(negedge clk);
        buf_valid = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_hsync"}, 32'(hsync_n), 32'd1);
    check_eq({tag, "_vsync"}, 32'(vsync_n), 32'd1);
    check_eq({tag, "_bgr"}, 32'(bgr), 32'd0);
    check_eq({tag, "_vblank"}, 32'(vga_vblank), 32'd1);
    check_eq({tag, "_en"}, 32'(vga_en), 32'd0);
    check_eq({tag, "_x"}, 32'(vga_x_group), 32'd0);
    check_eq({tag, "_y"}, 32'(vga_y_val), 32'd0);
    check_eq({tag, "_urun"}, 32'(underrun_cnt), 32'd0);
  endtask

  task automatic wait_frame(input int f);
    int n;
    n = 0;
    while (frm < f && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_wait", 32'(frm >= f), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b1;
    sb_on = 1'b1;
    resp_on = 1'b1;

    wait_frame(2);
    check_eq("underrun_f1", 32'(underrun_cnt), 32'd0);
    wait_frame(3);
    check_eq("underrun_f2", 32'(underrun_cnt), 32'd1);

    @(posedge clk);
    #2;
    resp_on = 1'b0;
    sb_on = 1'b0;
    n = 0;
    while (resp_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!vga_en && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_req_en", 32'(vga_en), 32'd1);

    rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vga_bgr_buf = fill(5'd7, 9'd7);
    buf_valid = 1'b1;
    @(negedge clk);
    buf_valid = 1'b0;
    check_eq("post_rst_en", 32'(vga_en), 32'd1);
    check_eq("post_rst_x", 32'(vga_x_group), 32'd0);
    check_eq("post_rst_y", 32'(vga_y_val), 32'd0);
    check_eq("post_rst_urun", 32'(underrun_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
